shared_qspi_arbiter: RTL and testbench
======================================

Name: shared_qspi_arbiter

Overview:
- Shares one external QSPI pad group (CSB, SCLK, IO[3:0] with per-bit OEB) between NUM_REQ on-chip requesters, e.g. the texture-ROM reader and the SPI register/vector loaders.
- Round-robin arbitration with a guaranteed bus-idle guard gap between owners.
- Output sits directly in front of the user_project_wrapper pad mapping.
- Shared input pads fan out unmuxed to all requesters; only the owner's outputs reach the pads.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GUARD_CYCLES, 2, idle cycles between release and next grant (1..15).
- HOLD_MAX, 1023, maximum consecutive cycles one owner may hold the bus (watchdog; see Optional Feature).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_lock  in  1  1 = freeze arbitration: no new grants; current owner keeps the bus.
- i_req  in  NUM_REQ  per-requester bus request; held high for the whole ownership.
- i_csb  in  NUM_REQ  per-requester chip select.
- i_sclk  in  NUM_REQ  per-requester serial clock.
- i_out  in  4*NUM_REQ  per-requester IO out; requester k uses bits [4k+3:4k].
- i_oeb  in  4*NUM_REQ  per-requester IO OEB; 1 = input.
- o_gnt  out  NUM_REQ  one-hot grant, registered.
- o_csb  out  1  pad CSB.
- o_sclk  out  1  pad SCLK.
- o_out  out  4  pad IO out.
- o_oeb  out  4  pad IO OEB.
- o_busy  out  1  1 in GRANT or GUARD.
- o_timeout  out  1  one-cycle pulse on a forced revoke.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, o_gnt=0, o_busy=0, o_timeout=0, o_csb=1, o_sclk=0, o_out=0, o_oeb=4'b1111.
- States: IDLE, GRANT, GUARD. All state and o_gnt are registered.
- Pad outputs are combinational muxes of the owner's inputs, selected by the registered grant.
- Safe value in IDLE/GUARD: csb=1, sclk=0, out=0, oeb=1111.
- IDLE: if i_lock=0 and any i_req, choose the first requester at or after rr_ptr (modulo NUM_REQ). Next cycle: o_gnt set, GRANT, rr_ptr=winner+1 mod NUM_REQ.
  - Request-to-grant latency is exactly 1 cycle.
  - If i_lock=1, stay in IDLE.
- GRANT: the owner's i_csb/i_sclk/i_out/i_oeb pass to the pads. Other requesters' signals are ignored.
  - When the owner's i_req falls, the next cycle has o_gnt=0 and state GUARD; the guard counter loads GUARD_CYCLES.
  - i_lock has no effect in GRANT.
- GUARD: safe pad values. The counter decrements each cycle; at 1, go to IDLE.
  - Minimum gap from grant drop to next grant = GUARD_CYCLES + 1 cycles.
  - Requests are not evaluated in GUARD.
- Simultaneous requests: round-robin order from rr_ptr. No requester may be granted twice while another's request has been continuously pending.
- A requester raising i_req while another owns the bus waits; there is no preemption except the watchdog.
- Owner deasserting i_req and reasserting it in the same cycle window is treated as a release: GUARD runs, then normal arbitration.
- o_busy = (state != IDLE).
- Reset mid-transfer forces the pads to safe values immediately (async).

Optional Feature:
- Macro SHARED_ARB_WATCHDOG_EN.
- When defined: a hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When it reaches HOLD_MAX with i_req still high, the next cycle drops o_gnt, pulses o_timeout for 1 cycle and enters GUARD.
  - The revoked requester must drop i_req for at least 1 cycle before it can be granted again.
  - rr_ptr advances past it as normal.
- When undefined: no counter, o_timeout tied to 0, ownership unbounded.

Test Plan:
- Reset with i_req=4'b0000 → o_csb=1, o_sclk=0, o_oeb=1111, o_gnt=0000, o_busy=0.
- i_req=4'b0100 at cycle 0 → o_gnt=0100 at cycle 1; drive i_csb[2]=0, i_out[11:8]=4'hA, i_oeb[11:8]=4'h0 → o_csb=0, o_out=A, o_oeb=0000 that cycle.
- i_req=4'b1111 held, each owner releases after 5 cycles → grant order 0001,0010,0100,1000,0001. Each gap of o_gnt=0 is exactly GUARD_CYCLES+1=3 cycles with safe pad values.
- Owner 1 granted, i_lock raised → owner keeps the bus. After release, no grant while i_lock=1 even with i_req=1101. Lock drop → grant 0100 next cycle (rr_ptr=2).
- Assert i_rst_n=0 mid-GRANT with i_csb[0]=0 → o_csb=1, o_gnt=0 asynchronously, before the next clock edge.
- With SHARED_ARB_WATCHDOG_EN and HOLD_MAX=16: requester 0 holds i_req → o_gnt drops after 16 GRANT cycles, o_timeout=1 for one cycle, requester 3 (pending) granted after guard; requester 0 not regranted until it drops i_req.

Source files
------------

// File: rtl/shared_qspi_arbiter.sv
// Round-robin owner of one QSPI pad group shared by NUM_REQ requesters, with an idle guard gap.
// Define SHARED_ARB_WATCHDOG_EN to revoke owners that hold the bus for HOLD_MAX cycles.

module shared_qspi_arbiter_lane (
  input  logic       gnt,
  input  logic       csb,
  input  logic       sclk,
  input  logic [3:0] out,
  input  logic [3:0] oeb,
  output logic       csb_act,
  output logic       sclk_m,
  output logic [3:0] out_m,
  output logic [3:0] oeb_act
);
  // Active-low pads are carried as active-high so that OR-reduction of all lanes gives the safe value when nobody is granted.
  assign csb_act = gnt & ~csb;
  assign sclk_m  = gnt & sclk;
  assign out_m   = {4{gnt}} & out;
  assign oeb_act = {4{gnt}} & ~oeb;
endmodule

module shared_qspi_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GUARD_CYCLES = 2,
  parameter int HOLD_MAX     = 1023
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_lock,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ-1:0]   i_csb,
  input  logic [NUM_REQ-1:0]   i_sclk,
  input  logic [4*NUM_REQ-1:0] i_out,
  input  logic [4*NUM_REQ-1:0] i_oeb,
  output logic [NUM_REQ-1:0]   o_gnt,
  output logic                 o_csb,
  output logic                 o_sclk,
  output logic [3:0]           o_out,
  output logic [3:0]           o_oeb,
  output logic                 o_busy,
  output logic                 o_timeout
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int HW = $clog2(HOLD_MAX + 1);

  if (NUM_REQ < 2 || GUARD_CYCLES < 1 || HOLD_MAX < 1) begin : g_bad_cfg
    $error("shared_qspi_arbiter: bad parameters (HW=%0d)", HW);
  end

  typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

  state_t                    state;
  logic [PW-1:0]             rr_ptr, owner, pick, rr_nxt;
  logic                      pick_vld;
  logic [GW-1:0]             guard_cnt;
  logic [NUM_REQ-1:0]        req_ok, rot;
  logic [NUM_REQ-1:0][3:0]   out_v, oeb_v, out_m, oeb_act;
  logic [NUM_REQ-1:0]        csb_act, sclk_m;
  logic [3:0]                out_or, oeb_or;

`ifdef SHARED_ARB_WATCHDOG_EN
  logic [HW-1:0]             hold_cnt;
  logic [NUM_REQ-1:0]        blocked;
  assign req_ok = i_req & ~blocked;
`else
  assign req_ok    = i_req;
  assign o_timeout = 1'b0;
`endif

  // Rotate so bit 0 is rr_ptr; the lowest set bit is the round-robin winner.
  always_comb begin
    int s;
    s        = 0;
    pick     = '0;
    pick_vld = 1'b0;
    rot      = NUM_REQ'({req_ok, req_ok} >> rr_ptr);
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (rot[i]) begin
        s = int'(rr_ptr) + i;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        pick     = PW'(s);
        pick_vld = 1'b1;
      end
    end
    rr_nxt = (pick == PW'(NUM_REQ-1)) ? '0 : pick + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      o_gnt     <= '0;
      guard_cnt <= '0;
`ifdef SHARED_ARB_WATCHDOG_EN
      hold_cnt  <= '0;
      blocked   <= '0;
      o_timeout <= 1'b0;
`endif
    end else begin
`ifdef SHARED_ARB_WATCHDOG_EN
      o_timeout <= 1'b0;
      blocked   <= blocked & i_req;
`endif
      case (state)
        IDLE: if (!i_lock && pick_vld) begin
          state  <= GRANT;
          owner  <= pick;
          o_gnt  <= NUM_REQ'(1) << pick;
          rr_ptr <= rr_nxt;
`ifdef SHARED_ARB_WATCHDOG_EN
          hold_cnt <= '0;
`endif
        end
        GRANT: if (!i_req[owner]) begin
          state     <= GUARD;
          o_gnt     <= '0;
          guard_cnt <= GW'(GUARD_CYCLES);
        end
`ifdef SHARED_ARB_WATCHDOG_EN
        else if (hold_cnt == HW'(HOLD_MAX-1)) begin
          state          <= GUARD;
          o_gnt          <= '0;
          guard_cnt      <= GW'(GUARD_CYCLES);
          o_timeout      <= 1'b1;
          blocked[owner] <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
`endif
        GUARD: if (guard_cnt == GW'(1)) state <= IDLE;
               else guard_cnt <= guard_cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  assign out_v = i_out;
  assign oeb_v = i_oeb;

  shared_qspi_arbiter_lane u_lane [NUM_REQ-1:0] (
    .gnt(o_gnt), .csb(i_csb), .sclk(i_sclk), .out(out_v), .oeb(oeb_v),
    .csb_act(csb_act), .sclk_m(sclk_m), .out_m(out_m), .oeb_act(oeb_act)
  );

  always_comb begin
    out_or = '0;
    oeb_or = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      out_or = out_or | out_m[i];
      oeb_or = oeb_or | oeb_act[i];
    end
  end

  assign o_csb  = ~|csb_act;
  assign o_sclk = |sclk_m;
  assign o_out  = out_or;
  assign o_oeb  = ~oeb_or;
  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_shared_qspi_arbiter.sv
// Scoreboard bench for shared_qspi_arbiter: grant order, guard gaps, pad muxing, lock, reset, watchdog.

module tb_shared_qspi_arbiter;
  localparam int N = 4;

  logic clk = 1'b0, rst_n = 1'b1, lock = 1'b0;
  logic [N-1:0] req = '0, csb = '1, sclk = '0;
  logic [4*N-1:0] out = '0, oeb = '1;
  logic [N-1:0] gnt;
  logic pcsb, psclk, busy, tmo;
  logic [3:0] pout, poeb;

  always #5 clk = ~clk;

  shared_qspi_arbiter #(.NUM_REQ(N), .GUARD_CYCLES(2), .HOLD_MAX(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_lock(lock), .i_req(req), .i_csb(csb),
    .i_sclk(sclk), .i_out(out), .i_oeb(oeb), .o_gnt(gnt), .o_csb(pcsb),
    .o_sclk(psclk), .o_out(pout), .o_oeb(poeb), .o_busy(busy), .o_timeout(tmo)
  );

  typedef struct { logic [N-1:0] gnt; int gap; } exp_t;
  exp_t expq[$];
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input logic [N-1:0] g, input int gap);
    exp_t e;
    e.gnt = g;
    e.gap = gap;
    expq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; lock = 1'b0; req = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_gnt(output logic [N-1:0] g);
    g = '0;
    for (int c = 0; c < 40 && g == '0; c++) begin
      @(negedge clk);
      g = gnt;
    end
    chk("grant_seen_in_bound", (g != '0), 1);
  endtask

  // Monitor: every new grant is popped against the scoreboard; gap length and pad safety are checked too.
  logic [N-1:0] prev_gnt = '0;
  int zero_run = 0, to_pulses = 0;
  bit unsafe = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gnt = '0; zero_run = 0; unsafe = 0;
    end else begin
      if (tmo === 1'b1) to_pulses++;
      if (gnt == '0) begin
        zero_run++;
        if (pcsb !== 1'b1 || psclk !== 1'b0 || pout !== 4'h0 || poeb !== 4'hF) unsafe = 1;
      end else if (prev_gnt == '0) begin
        if (expq.size() == 0) chk("unexpected_grant", gnt, 0);
        else begin
          exp_t e;
          e = expq.pop_front();
          chk("grant_order", gnt, e.gnt);
          chk("grant_onehot", $onehot(gnt), 1);
          if (e.gap >= 0) begin
            chk("guard_gap", zero_run, e.gap);
            chk("gap_safe_pads", unsafe, 0);
          end
        end
        zero_run = 0;
        unsafe = 0;
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    logic [N-1:0] cur;
    int held;
    // Reset with every requester driving non-safe pad values.
    csb = '0; sclk = '1; out = '1; oeb = '0;
    #1 rst_n = 1'b0;
    #11;
    chk("reset_csb", pcsb, 1);
    chk("reset_sclk", psclk, 0);
    chk("reset_out", pout, 0);
    chk("reset_oeb", poeb, 4'hF);
    chk("reset_gnt", gnt, 0);
    chk("reset_busy", busy, 0);
    chk("reset_timeout", tmo, 0);

    // Single requester 2: one-cycle latency and pad pass-through.
    do_reset();
    csb = 4'b1011; sclk = 4'b1011; out = 16'h5A55; oeb = 16'hF0FF;
    req = 4'b0100;
    push(4'b0100, -1);
    @(negedge clk);
    chk("latency_not_early", gnt, 0);
    @(negedge clk);
    chk("latency_one_cycle", gnt, 4'b0100);
    chk("pad_csb", pcsb, 0);
    chk("pad_out", pout, 4'hA);
    chk("pad_oeb", poeb, 4'h0);
    chk("pad_sclk", psclk, 0);
    chk("busy_grant", busy, 1);
    #1 sclk[2] = 1'b1;
    #1 chk("pad_sclk_follow", psclk, 1);
    tick();
    req = '0;
    repeat (6) tick();

    // All four requesting: round-robin with 3-cycle gaps.
    do_reset();
    csb = '0; sclk = '1; out = '1; oeb = '0;
    req = '1;
    push(4'b0001, -1); push(4'b0010, 3); push(4'b0100, 3); push(4'b1000, 3); push(4'b0001, 3);
    for (int g = 0; g < 5; g++) begin
      wait_gnt(cur);
      repeat (5) @(posedge clk);
      #1;
      if (g == 4) req = '0;
      else req = req & ~cur;
      tick();
      if (g != 4) req = '1;
    end
    repeat (6) tick();

    // Lock: owner keeps bus; no grant while locked; unlock grants rr_ptr=2.
    do_reset();
    csb = '1; sclk = '0; out = '0; oeb = '1;
    req = 4'b0010;
    push(4'b0010, -1);
    wait_gnt(cur);
    lock = 1'b1;
    repeat (4) tick();
    chk("lock_keeps_owner", gnt, 4'b0010);
    req = 4'b1101;
    repeat (10) tick();
    chk("lock_no_grant", gnt, 0);
    chk("lock_idle_busy", busy, 0);
    push(4'b0100, -1);
    lock = 1'b0;
    @(negedge clk);
    chk("unlock_not_early", gnt, 0);
    @(negedge clk);
    chk("unlock_grant", gnt, 4'b0100);
    tick();
    req = '0;
    repeat (6) tick();

    // Asynchronous reset mid-grant.
    do_reset();
    csb = 4'b1110;
    req = 4'b0001;
    push(4'b0001, -1);
    wait_gnt(cur);
    chk("pre_reset_csb", pcsb, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_csb", pcsb, 1);
    chk("async_reset_gnt", gnt, 0);
    chk("async_reset_busy", busy, 0);
    tick();

    // Long hold by requester 0.
    do_reset();
    csb = '0; sclk = '1; out = '1; oeb = '0;
    req = 4'b0001;
    push(4'b0001, -1);
`ifdef SHARED_ARB_WATCHDOG_EN
    push(4'b1000, 3);
`endif
    wait_gnt(cur);
`ifdef SHARED_ARB_WATCHDOG_EN
    req[3] = 1'b1;
`endif
    held = 0;
    for (int c = 0; c < 60; c++) begin
      if (gnt != 4'b0001) break;
      held++;
      @(negedge clk);
    end
`ifdef SHARED_ARB_WATCHDOG_EN
    chk("wd_hold_cycles", held, 16);
    chk("wd_timeout_pulse", tmo, 1);
    @(negedge clk);
    chk("wd_timeout_one_cycle", tmo, 0);
    wait_gnt(cur);
    repeat (3) tick();
    req[3] = 1'b0;
    repeat (10) tick();
    chk("wd_no_regrant", gnt, 0);
    chk("wd_idle_busy", busy, 0);
    push(4'b0001, -1);
    req[0] = 1'b0;
    tick();
    req[0] = 1'b1;
    wait_gnt(cur);
    chk("wd_regrant_after_drop", cur, 4'b0001);
    chk("timeout_pulse_count", to_pulses, 1);
`else
    chk("nowd_hold_unbounded", held, 60);
    chk("nowd_still_granted", gnt, 4'b0001);
    chk("timeout_pulse_count", to_pulses, 0);
`endif
    tick();
    req = '0;
    repeat (8) tick();
    chk("scoreboard_drained", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
